// File: rtl/mem_arbiter.sv
// Arbitrates one shared single-port memory between an instruction fetch port and a
// data port, with fetch starvation protection and a sticky timeout on mem_ready.
module mem_arbiter #(
  parameter int N          = 64,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_req,
  input  logic [31:0]  i_adr,
  output logic         i_ack,
  output logic [31:0]  i_rdata,
  input  logic         d_req,
  input  logic [1:0]   d_we,
  input  logic         d_dword,
  input  logic [N-1:0] d_adr,
  input  logic [N-1:0] d_wdata,
  output logic         d_ack,
  output logic [N-1:0] d_rdata,
  output logic         mem_req,
  output logic [1:0]   mem_we,
  output logic         mem_dword,
  output logic [N-1:0] mem_adr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata,
  input  logic         mem_ready,
  output logic         stall,
  output logic         err
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [2:0]    STARVE_LIM = 3'(STARVE_MAX);
  localparam logic [WW-1:0] WAIT_LIM   = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t        state, state_nxt;
  logic          grant_i, grant_d, done, abort;
  logic          i_elig, d_elig;
  logic [2:0]    starve_cnt;
  logic [WW-1:0] wait_cnt;

  // A port whose ack is showing is still holding its finished request.
  assign i_elig = i_req & ~i_ack;
  assign d_elig = d_req & ~d_ack;
  assign stall  = i_elig | d_elig;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (d_elig && !(i_elig && starve_cnt == STARVE_LIM)) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
        end else if (i_elig) begin
          grant_i   = 1'b1;
          state_nxt = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (wait_cnt == WAIT_LIM) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req    <= 1'b0;
      mem_we     <= 2'b00;
      mem_dword  <= 1'b0;
      mem_adr    <= '0;
      mem_wdata  <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      starve_cnt <= '0;
      wait_cnt   <= '0;
      err        <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;

      if (grant_i) begin
        mem_req    <= 1'b1;
        mem_we     <= 2'b00;
        mem_dword  <= 1'b0;
        mem_adr    <= {{(N-32){1'b0}}, i_adr};
        mem_wdata  <= '0;
        wait_cnt   <= '0;
        starve_cnt <= '0;
      end

      if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_dword <= d_dword | d_we[1];
        mem_adr   <= d_adr;
        mem_wdata <= d_wdata;
        wait_cnt  <= '0;
        // Only a fetch that is actually waiting counts as being passed over.
        if (i_elig && starve_cnt != STARVE_LIM)
          starve_cnt <= starve_cnt + 3'd1;
      end

      if (done || abort) begin
        mem_req  <= 1'b0;
        wait_cnt <= '0;
        if (abort) err <= 1'b1;
        if (state == BUSY_I) begin
          i_ack <= 1'b1;
          if (abort)           i_rdata <= '0;
          else if (mem_adr[2]) i_rdata <= mem_rdata[63:32];
          else                 i_rdata <= mem_rdata[31:0];
        end else begin
          d_ack <= 1'b1;
          if (abort)                 d_rdata <= '0;
          else if (mem_we == 2'b00)  d_rdata <= mem_rdata;
        end
      end else if (state != IDLE) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change on the falling edge, registered
// outputs are sampled there too, one full cycle after the edge that produced them.
module tb_mem_arbiter;
  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         i_req, i_ack;
  logic [31:0]  i_adr, i_rdata;
  logic         d_req, d_dword, d_ack;
  logic [1:0]   d_we;
  logic [N-1:0] d_adr, d_wdata, d_rdata;
  logic         mem_req, mem_dword, mem_ready;
  logic [1:0]   mem_we;
  logic [N-1:0] mem_adr, mem_wdata, mem_rdata;
  logic         stall, err;

  int vectors = 0;
  int miscompares = 0;
  int stall_cycles;

  mem_arbiter #(.N(N), .STARVE_MAX(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_adr(i_adr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_dword(d_dword), .d_adr(d_adr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_dword(mem_dword),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic ireq, input logic [31:0] iadr, input logic dreq,
                               input logic [1:0] dwe, input logic ddw,
                               input logic [63:0] dadr, input logic [63:0] dwd);
    i_req   = ireq;
    i_adr   = iadr;
    d_req   = dreq;
    d_we    = dwe;
    d_dword = ddw;
    d_adr   = dadr;
    d_wdata = dwd;
  endtask

  task automatic setMem(input logic rdy, input logic [63:0] rd);
    mem_ready = rdy;
    mem_rdata = rd;
  endtask

  task automatic nextCycle;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(0, 32'h0, 0, 2'b00, 0, 64'h0, 64'h0);
    setMem(0, 64'h0);
    repeat (2) nextCycle;
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_i_ack", i_ack, 0);
    checkOutput("rst_d_ack", d_ack, 0);
    checkOutput("rst_i_rdata", i_rdata, 0);
    checkOutput("rst_d_rdata", d_rdata, 0);
    checkOutput("rst_mem_adr", mem_adr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_stall", stall, 0);
    reset = 1'b1;
    nextCycle;

    // Single fetch, minimum latency, upper word selected by i_adr[2].
    applyStimulus(1, 32'h4, 0, 2'b00, 0, 64'h0, 64'h0);
    nextCycle;
    checkOutput("f_mem_req", mem_req, 1);
    checkOutput("f_mem_adr", mem_adr, 64'h4);
    checkOutput("f_mem_we", mem_we, 0);
    checkOutput("f_early_ack", i_ack, 0);
    setMem(1, 64'h11112222_33334444);
    nextCycle;
    checkOutput("f_i_ack", i_ack, 1);
    checkOutput("f_i_rdata", i_rdata, 64'h11112222);
    checkOutput("f_mem_req_off", mem_req, 0);
    checkOutput("f_stall_ack", stall, 0);
    applyStimulus(0, 32'h0, 0, 2'b00, 0, 64'h0, 64'h0);
    setMem(0, 64'h0);
    nextCycle;
    checkOutput("f_ack_pulse", i_ack, 0);

    // Simultaneous requests: data write first, then the fetch.
    applyStimulus(1, 32'h8, 1, 2'b01, 0, 64'h100, 64'hCAFE);
    nextCycle;
    checkOutput("both_d_adr", mem_adr, 64'h100);
    checkOutput("both_d_we", mem_we, 2'b01);
    checkOutput("both_d_wdata", mem_wdata, 64'hCAFE);
    checkOutput("both_d_dword", mem_dword, 0);
    setMem(1, 64'h0);
    nextCycle;
    checkOutput("both_d_ack", d_ack, 1);
    checkOutput("both_i_ack_early", i_ack, 0);
    applyStimulus(1, 32'h8, 0, 2'b00, 0, 64'h0, 64'h0);
    setMem(0, 64'h0);
    nextCycle;
    checkOutput("both_f_req", mem_req, 1);
    checkOutput("both_f_adr", mem_adr, 64'h8);
    checkOutput("both_f_we", mem_we, 0);
    checkOutput("both_d_ack_pulse", d_ack, 0);
    setMem(1, 64'hAAAABBBB_CCCCDDDD);
    nextCycle;
    checkOutput("both_i_ack", i_ack, 1);
    checkOutput("both_i_rdata", i_rdata, 64'hCCCCDDDD);
    checkOutput("both_d_rdata_write", d_rdata, 0);
    applyStimulus(0, 32'h0, 0, 2'b00, 0, 64'h0, 64'h0);
    setMem(0, 64'h0);
    nextCycle;

    // Four data grants while the fetch is pending at each grant; the fifth goes to fetch.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 32'h44, 1, 2'b01, 0, 64'h1000 + 64'(k * 8), 64'(k));
      nextCycle;
      checkOutput($sformatf("starve_d_adr%0d", k), mem_adr, 64'h1000 + 64'(k * 8));
      applyStimulus(0, 32'h44, 1, 2'b01, 0, 64'h1000 + 64'(k * 8), 64'(k));
      setMem(1, 64'h0);
      nextCycle;
      checkOutput($sformatf("starve_d_ack%0d", k), d_ack, 1);
      setMem(0, 64'h0);
      nextCycle;
    end
    applyStimulus(1, 32'h44, 1, 2'b01, 0, 64'h2000, 64'h9);
    nextCycle;
    checkOutput("starve_f_adr", mem_adr, 64'h44);
    checkOutput("starve_f_we", mem_we, 0);
    setMem(1, 64'h55556666_77778888);
    nextCycle;
    checkOutput("starve_i_ack", i_ack, 1);
    checkOutput("starve_i_rdata", i_rdata, 64'h55556666);
    checkOutput("starve_no_d_ack", d_ack, 0);
    applyStimulus(0, 32'h0, 1, 2'b01, 0, 64'h2000, 64'h9);
    setMem(0, 64'h0);
    nextCycle;
    checkOutput("starve_d_after", mem_adr, 64'h2000);
    checkOutput("starve_d_req", mem_req, 1);
    setMem(1, 64'h0);
    nextCycle;
    checkOutput("starve_d_ack_last", d_ack, 1);
    applyStimulus(0, 32'h0, 0, 2'b00, 0, 64'h0, 64'h0);
    setMem(0, 64'h0);
    nextCycle;

    // Doubleword read with mem_ready on the third command cycle.
    stall_cycles = 0;
    applyStimulus(0, 32'h0, 1, 2'b00, 1, 64'h200, 64'h0);
    #1 if (stall) stall_cycles++;
    nextCycle;
    checkOutput("dw_mem_dword", mem_dword, 1);
    checkOutput("dw_mem_we", mem_we, 0);
    checkOutput("dw_mem_req", mem_req, 1);
    if (stall) stall_cycles++;
    nextCycle;
    if (stall) stall_cycles++;
    nextCycle;
    setMem(1, 64'hDEADBEEF_01234567);
    #1 if (stall) stall_cycles++;
    nextCycle;
    if (stall) stall_cycles++;
    checkOutput("dw_d_ack", d_ack, 1);
    checkOutput("dw_d_rdata", d_rdata, 64'hDEADBEEF_01234567);
    checkOutput("dw_mem_req_off", mem_req, 0);
    checkOutput("dw_stall_cycles", 64'(stall_cycles), 4);
    applyStimulus(0, 32'h0, 0, 2'b00, 0, 64'h0, 64'h0);
    setMem(0, 64'h0);
    nextCycle;

    // Memory never answers: abort after 16 busy cycles, error sticks.
    applyStimulus(0, 32'h0, 1, 2'b00, 0, 64'h300, 64'h0);
    for (int c = 1; c <= 16; c++) begin
      nextCycle;
      checkOutput($sformatf("to_wait_ack%0d", c), d_ack, 0);
    end
    checkOutput("to_mem_req_c16", mem_req, 1);
    checkOutput("to_err_before", err, 0);
    nextCycle;
    checkOutput("to_d_ack", d_ack, 1);
    checkOutput("to_d_rdata", d_rdata, 0);
    checkOutput("to_err", err, 1);
    checkOutput("to_mem_req_off", mem_req, 0);
    applyStimulus(0, 32'h0, 0, 2'b00, 0, 64'h0, 64'h0);
    nextCycle;
    setMem(1, 64'hFFFFFFFF_FFFFFFFF);
    nextCycle;
    checkOutput("late_d_ack", d_ack, 0);
    checkOutput("late_i_ack", i_ack, 0);
    checkOutput("late_mem_req", mem_req, 0);
    checkOutput("late_err", err, 1);
    checkOutput("late_d_rdata", d_rdata, 0);
    setMem(0, 64'h0);
    nextCycle;

    // Reset in the middle of a data access.
    applyStimulus(0, 32'h0, 1, 2'b10, 0, 64'h400, 64'h77);
    nextCycle;
    checkOutput("rs_mem_req", mem_req, 1);
    checkOutput("rs_mem_dword", mem_dword, 1);
    checkOutput("rs_mem_we", mem_we, 2'b10);
    #2 reset = 1'b0;
    #1;
    checkOutput("rs_async_mem_req", mem_req, 0);
    checkOutput("rs_async_err", err, 0);
    checkOutput("rs_async_mem_adr", mem_adr, 0);
    nextCycle;
    checkOutput("rs_no_d_ack", d_ack, 0);
    reset = 1'b1;
    nextCycle;
    checkOutput("rs_regrant_req", mem_req, 1);
    checkOutput("rs_regrant_adr", mem_adr, 64'h400);
    checkOutput("rs_regrant_no_ack", d_ack, 0);
    setMem(1, 64'h0);
    nextCycle;
    checkOutput("rs_d_ack", d_ack, 1);
    checkOutput("rs_d_rdata_write", d_rdata, 0);
    applyStimulus(0, 32'h0, 0, 2'b00, 0, 64'h0, 64'h0);
    setMem(0, 64'h0);
    nextCycle;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
